// File: rtl/turbo_addr_pkg.sv
// turbo_addr_pkg: shared widths, FSM encoding and mode/direction codes for the interleaver address stream
package turbo_addr_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int Q_W_DEF = 3;
  localparam int LEN_W_DEF = 13;
  typedef enum logic {IDLE, RUN} stateT;
  localparam logic MODE_ILV = 1'b0;
  localparam logic MODE_NAT = 1'b1;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;
endpackage

// File: rtl/turbo_modstep.sv
// turbo_modstep: one mixed-radix stage, (qa,ra) +/- (qb,rb) with R mod bs carrying/borrowing into Q mod dec
// ports: sub selects subtract; ra/rb/bs remainder operands and modulus; qa/qb/dec quotient operands and modulus; r/q result
module turbo_modstep import turbo_addr_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Q_W = Q_W_DEF
) (
  input  logic              sub,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] bs,
  input  logic [Q_W-1:0]    qa,
  input  logic [Q_W-1:0]    qb,
  input  logic [Q_W:0]      dec,
  output logic [ADDR_W-1:0] r,
  output logic [Q_W-1:0]    q
);
  logic [ADDR_W+1:0] bsX, rSum, rDiff, rW;
  logic [Q_W+1:0] decX, qSum, qDiff, qW;
  logic k;
  always_comb begin
    bsX = {2'b0, bs};
    decX = {1'b0, dec};
    rSum = {2'b0, ra} + {2'b0, rb};
    rDiff = {2'b0, ra} - {2'b0, rb};
    // carry on add, borrow (sign of the widened difference) on subtract
    k = sub ? rDiff[ADDR_W+1] : (rSum >= bsX);
    rW = sub ? (k ? rDiff + bsX : rDiff) : (k ? rSum - bsX : rSum);
    qSum = {2'b0, qa} + {2'b0, qb} + {{(Q_W+1){1'b0}}, k};
    qDiff = {2'b0, qa} - {2'b0, qb} - {{(Q_W+1){1'b0}}, k};
    qW = sub ? (qDiff[Q_W+1] ? qDiff + decX : qDiff) : (qSum >= decX ? qSum - decX : qSum);
    r = rW[ADDR_W-1:0];
    q = qW[Q_W-1:0];
  end
endmodule

// File: rtl/turbo_addr_stream.sv
// turbo_addr_stream: interleaver address stream (QPP-style second-order recurrence or natural order), forward or backward
// ports: clk, reset (async active-low); start/abort control; dir/mode/len/blockSize/decNum/Rf2/Qf2 and *_init latched at start;
//        out_valid/out_ready handshake carrying out_rf/out_qf with out_last on the final address; busy while running; done pulse at end
module turbo_addr_stream import turbo_addr_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Q_W = Q_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic              mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] blockSize,
  input  logic [Q_W:0]      decNum,
  input  logic [ADDR_W-1:0] Rf2,
  input  logic [Q_W-1:0]    Qf2,
  input  logic [ADDR_W-1:0] rf_init,
  input  logic [ADDR_W-1:0] rg_init,
  input  logic [Q_W-1:0]    qf_init,
  input  logic [Q_W-1:0]    qg_init,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_rf,
  output logic [Q_W-1:0]    out_qf,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam logic [LEN_W-1:0] CNT_ONE = 1;
  localparam logic [Q_W:0] DEC_ONE = 1;
  localparam logic [ADDR_W-1:0] R_ONE = 1;
  stateT state, nextState;
  logic dirR, modeR;
  logic [ADDR_W-1:0] bsR, rf2R, rf, rg, rgN, rfN, fOpR;
  logic [Q_W:0] decR;
  logic [Q_W-1:0] qf2R, qf, qg, qgN, qfN, fOpQ;
  logic [LEN_W-1:0] count;
  logic fwd, ilv, lastAddr, handshake, load, step, decOne;
  assign out_valid = state == RUN;
  assign busy = state != IDLE;
  assign lastAddr = count == CNT_ONE;
  assign out_last = out_valid && lastAddr;
  assign handshake = out_valid && out_ready;
  assign load = !abort && state == IDLE && start && |len;
  assign step = !abort && handshake && !lastAddr;
  assign out_rf = rf;
  assign out_qf = qf;
  assign fwd = dirR == DIR_FWD;
  assign ilv = modeR == MODE_ILV;
  assign decOne = decNum == DEC_ONE;
  // forward f uses the old g; backward f uses the already-reversed g so the step is an exact inverse
  assign fOpR = ilv ? (fwd ? rg : rgN) : R_ONE;
  assign fOpQ = ilv ? (fwd ? qg : qgN) : '0;
  turbo_modstep #(.ADDR_W(ADDR_W), .Q_W(Q_W)) gStep (
    .sub(!fwd), .ra(rg), .rb(rf2R), .bs(bsR), .qa(qg), .qb(qf2R), .dec(decR), .r(rgN), .q(qgN)
  );
  turbo_modstep #(.ADDR_W(ADDR_W), .Q_W(Q_W)) fStep (
    .sub(!fwd), .ra(rf), .rb(fOpR), .bs(bsR), .qa(qf), .qb(fOpQ), .dec(decR), .r(rfN), .q(qfN)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    if (abort) nextState = IDLE;
    else if (load) nextState = RUN;
    else if (handshake && lastAddr) nextState = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      done <= 1'b0;
      dirR <= 1'b0;
      modeR <= 1'b0;
      bsR <= '0;
      decR <= '0;
      rf2R <= '0;
      qf2R <= '0;
      rf <= '0;
      qf <= '0;
      rg <= '0;
      qg <= '0;
      count <= '0;
    end else begin
      done <= !abort && ((state == IDLE && start && !(|len)) || (handshake && lastAddr));
      if (load) begin
        dirR <= dir;
        modeR <= mode;
        bsR <= blockSize;
        decR <= decNum;
        rf2R <= Rf2;
        // a single-quotient block keeps every Q field at 0
        qf2R <= decOne ? '0 : Qf2;
        rf <= rf_init;
        qf <= decOne ? '0 : qf_init;
        rg <= rg_init;
        qg <= decOne ? '0 : qg_init;
        count <= len;
      end else if (step) begin
        rf <= rfN;
        qf <= qfN;
        rg <= ilv ? rgN : rg;
        qg <= ilv ? qgN : qg;
        count <= count - CNT_ONE;
      end
    end
endmodule
